mem_backing_responder: RTL and testbench

Word-addressed backing memory that acts as the responder on the cache-miss/refill interface. Its requester is the instruction/data cache controller. It accepts one read or byte-masked write request at a time. It models a fixed, parameterised access latency, then returns a single-cycle response pulse carrying read data or the write acknowledgement. It sits below the cache and is the far end of the miss/writeback handshake.

---
 rtl/mem_backing_responder.sv | 141 ++++++++++++++
 tb/tb_mem_backing_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_backing_responder.sv
// mem_backing_responder
// Word-addressed backing memory acting as the responder on the cache
// miss/refill interface. Accepts one read or byte-masked write at a time,
// waits a fixed LATENCY, then pulses resp_valid for one cycle with the read
// data or the merged written word.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   req_valid         request present (held by requester until req_ready)
//   req_write         1 = write, 0 = read
//   req_addr[31:0]    word address, low DEPTH_LOG2 bits used (wraps)
//   req_wdata[31:0]   write data
//   req_be[3:0]       byte enables, bit i -> byte [8i+7:8i]
//   req_ready         idle, able to accept a request
//   resp_valid        one-cycle response pulse
//   resp_rdata[31:0]  read data or merged written word; held outside RESP
//   busy              a request is in flight
module mem_backing_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4,
  parameter string       MEM_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  accept, access;

  logic [DEPTH_LOG2-1:0] addr_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;

  logic [31:0]           mem [0:DEPTH-1];
  logic [31:0]           cur_word;
  logic [31:0]           merged;

  // Upper address bits are deliberately ignored (modulo addressing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_n   = LAT_M1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access  = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

  // Request fields are captured only on acceptance so that inputs changing
  // mid-flight cannot affect the transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      addr_q  <= req_addr[DEPTH_LOG2-1:0];
      write_q <= req_write;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  assign cur_word = mem[addr_q];

  always_comb begin
    merged = cur_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Storage has no reset. A write cut short by reset never reaches the
  // access edge because the FSM is already forced back to IDLE.
  always_ff @(posedge clk) begin
    if (access && write_q) mem[addr_q] <= merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= '0;
    end else if (access) begin
      resp_rdata <= write_q ? merged : cur_word;
    end
  end

endmodule

// File: tb/tb_mem_backing_responder.sv
// Bench for mem_backing_responder: two instances (LATENCY=4 and LATENCY=1)
// share request data inputs; each has its own req_valid and outputs.
// Expected responses come from a bench-side memory model and are queued
// per instance; a negedge monitor pops and compares them.
module tb_mem_backing_responder;

  localparam int unsigned LAT [2] = '{4, 1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  vld = '0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [1:0]  rdy, rv, bsy;
  logic [31:0] rdata [2];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          sel = 0;

  logic [31:0] exp_q [2][$];
  int          acc_q [2][$];
  logic [31:0] model [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_backing_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_write(wr),
    .req_addr(addr), .req_wdata(wdata), .req_be(be),
    .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rdata[0]), .busy(bsy[0])
  );

  mem_backing_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_write(wr),
    .req_addr(addr), .req_wdata(wdata), .req_be(be),
    .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rdata[1]), .busy(bsy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Response monitor: one expected entry per response pulse, on the right edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rv[d] === 1'b1) begin
        if (exp_q[d].size() == 0) begin
          check("spurious_resp", 32'(rv[d]), 32'd0);
        end else begin
          check("resp_data", rdata[d], exp_q[d].pop_front());
          check("resp_cycle", 32'(cyc), 32'(acc_q[d].pop_front() + int'(LAT[d])));
          check("resp_ready_low", 32'(rdy[d]), 32'd0);
        end
      end
    end
  end

  // Returns at #1 after the acceptance edge.
  task automatic wait_accept(input bit track, output int edge_cyc);
    bit done = 1'b0;
    edge_cyc = -1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (rdy[sel] && vld[sel]) begin
        edge_cyc = cyc + 1;
        if (track) acc_q[sel].push_back(edge_cyc);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
    int key = sel * 4096 + int'(a % 1024);
    logic [31:0] word = model.exists(key) ? model[key] : '0;
    for (int i = 0; i < 4; i++) if (w && b[i]) word[8*i +: 8] = d[8*i +: 8];
    if (w) model[key] = word;
    exp_q[sel].push_back(word);
    wr = w; addr = a; wdata = d; be = b;
    vld[sel] = 1'b1;
  endtask

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
    int e;
    set_req(w, a, d, b);
    wait_accept(1'b1, e);
    vld[sel] = 1'b0;
  endtask

  // Returns at #1 after the first posedge where no response is outstanding.
  task automatic drain;
    int n = 0;
    while (exp_q[sel].size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q[sel].size()), 32'd0);
  endtask

  initial begin
    int e, prev;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(rdy[d]), 32'd1);
      check("rst_valid", 32'(rv[d]), 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_busy", 32'(bsy[d]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single read at LATENCY=4 after loading the word.
    sel = 0;
    send(1'b1, 32'h12, 32'hDEADBEEF, 4'hF); drain();
    send(1'b0, 32'h12, 32'h0, 4'h0);
    check("rd_busy", 32'(bsy[0]), 32'd1);
    check("rd_ready_low", 32'(rdy[0]), 32'd0);
    drain();
    check("rd_ready_back", 32'(rdy[0]), 32'd1);
    check("rd_valid_low", 32'(rv[0]), 32'd0);

    // Byte-masked write over a known word, read back, then an empty mask.
    send(1'b1, 32'h20, 32'h11223344, 4'hF); drain();
    send(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101); drain();
    send(1'b0, 32'h20, 32'h0, 4'h0); drain();
    send(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000); drain();
    send(1'b0, 32'h20, 32'h0, 4'h0); drain();

    // Held req_valid, alternating addresses, junk inputs while busy.
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) set_req(1'b0, 32'h20, 32'h0, 4'h0);
      else            set_req(1'b1, 32'h12, 32'(k) * 32'h01010101, 4'b0011);
      wait_accept(1'b1, e);
      if (k > 0) check("b2b_gap", 32'(e - prev), 32'(LAT[0] + 2));
      prev = e;
      wr = 1'b1; addr = 32'h33; wdata = 32'h0BAD0BAD; be = 4'hF;
      drain();
    end
    vld[0] = 1'b0;
    send(1'b0, 32'h33, 32'h0, 4'h0); drain();
    send(1'b0, 32'h12, 32'h0, 4'h0); drain();

    // Reset two edges into a write: the write must be discarded.
    send(1'b1, 32'h5, 32'h0, 4'hF); drain();
    wr = 1'b1; addr = 32'h5; wdata = 32'hFFFFFFFF; be = 4'hF;
    vld[0] = 1'b1;
    wait_accept(1'b0, e);
    vld[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(rdy[0]), 32'd1);
    check("midrst_busy", 32'(bsy[0]), 32'd0);
    check("midrst_rdata", rdata[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("postrst_ready", 32'(rdy[0]), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    send(1'b0, 32'h5, 32'h0, 4'h0); drain();

    // LATENCY=1 and address wrap.
    sel = 1;
    send(1'b1, 32'h000, 32'hCAFEF00D, 4'hF); drain();
    send(1'b0, 32'h400, 32'h0, 4'h0); drain();
    send(1'b1, 32'h7FF, 32'h5A5A5A5A, 4'b1000); drain();
    send(1'b0, 32'h3FF, 32'h0, 4'h0); drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
